// File: rtl/pipeline_unit_elastic.sv
// pipeline_unit_elastic: elastic valid/ready register pipeline with global stall,
// immediate or wavefront flush, delayed flush marker and registered occupancy.
module pipeline_unit_elastic #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 3,
  parameter int FLUSH_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         stall,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH:1] v, v_nxt, adv, clr, fp, fp_nxt, src_v;
  logic [DATA_W-1:0] d     [1:DEPTH];
  logic [DATA_W-1:0] d_nxt [1:DEPTH];
  logic [DATA_W-1:0] src_d [1:DEPTH];
  logic [OW-1:0] cnt;
  // a stage advances when it is empty or everything downstream of it advances
  always_comb begin
    logic nxt;
    nxt = out_ready;
    adv = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      adv[k] = ~stall & (~v[k] | nxt);
      nxt = adv[k];
    end
  end
  assign in_ready  = adv[1] & ~flush;
  assign out_valid = v[DEPTH] & ~stall;
  assign out_data  = d[DEPTH];
  assign out_flush = fp[DEPTH];
  always_comb begin
    src_v    = '0;
    src_v[1] = in_valid & in_ready;
    src_d[1] = in_data;
    clr      = '0;
    clr[1]   = flush;
    fp_nxt   = '0;
    fp_nxt[1] = flush;
    for (int k = 2; k <= DEPTH; k++) begin
      src_v[k]  = v[k-1];
      src_d[k]  = d[k-1];
      clr[k]    = (FLUSH_MODE != 0) ? fp[k-1] : flush;
      fp_nxt[k] = fp[k-1];
    end
  end
  // a cleared stage takes nothing that cycle; data only moves behind a valid bit
  always_comb begin
    v_nxt = v;
    d_nxt = d;
    cnt   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (clr[k]) begin
        v_nxt[k] = 1'b0;
        d_nxt[k] = '0;
      end else if (adv[k]) begin
        v_nxt[k] = src_v[k];
        d_nxt[k] = src_v[k] ? src_d[k] : d[k];
      end
      cnt = cnt + OW'(v_nxt[k]);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v         <= '0;
      d         <= '{default: '0};
      fp        <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_nxt;
      d         <= d_nxt;
      fp        <= fp_nxt;
      occupancy <= cnt;
    end
  end
endmodule

// File: tb/tb_pipeline_unit_elastic.sv
// tb_pipeline_unit_elastic: three instances (depth 3 immediate flush, depth 3 wavefront
// flush, depth 1) checked each cycle against a slot-queue model plus literal expectations.
module tb_pipeline_unit_elastic;
  typedef struct packed {
    logic [3:1]        v;
    logic [3:1][31:0]  d;
    logic [3:1]        fp;
  } mst_t;

  logic clk = 0, reset_n = 0, in_valid = 0, flush = 0, stall = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic ir[3], ov[3], of[3];
  logic [31:0] od[3];
  logic [1:0] oc0, oc1;
  logic oc2;
  mst_t ms[3];
  int checks = 0, failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pipeline_unit_elastic #(.DATA_W(32), .DEPTH(3), .FLUSH_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .flush(flush), .stall(stall), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_flush(of[0]), .occupancy(oc0));
  pipeline_unit_elastic #(.DATA_W(32), .DEPTH(3), .FLUSH_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .flush(flush), .stall(stall), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_flush(of[1]), .occupancy(oc1));
  pipeline_unit_elastic #(.DATA_W(32), .DEPTH(1), .FLUSH_MODE(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .flush(flush), .stall(stall), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_flush(of[2]), .occupancy(oc2));

  function automatic int dep(int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic int mode(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // slots behind the furthest-downstream hole slide forward one place; new item enters slot 1
  function automatic mst_t step_model(mst_t s, int dp, int md, logic iv, logic [31:0] id,
                                      logic fl, logic st, logic ordy);
    mst_t n = s;
    int hole = 0;
    if (!st) begin
      if (s.v[dp] && ordy) n.v[dp] = 1'b0;
      for (int k = 1; k <= dp; k++) if (!n.v[k]) hole = k;
      for (int k = hole; k >= 2; k--) begin
        n.v[k] = n.v[k-1];
        n.d[k] = n.d[k-1];
      end
      if (hole >= 1) begin
        n.v[1] = iv && !fl;
        n.d[1] = id;
      end
    end
    for (int k = 1; k <= dp; k++) begin
      if ((md == 0) ? fl : (k == 1 ? fl : s.fp[k-1])) begin
        n.v[k] = 1'b0;
        n.d[k] = '0;
      end
    end
    n.fp[1] = fl;
    for (int k = 2; k <= dp; k++) n.fp[k] = s.fp[k-1];
    return n;
  endfunction

  function automatic logic m_in_ready(mst_t s, int dp, logic fl, logic st, logic ordy);
    logic room = s.v[dp] && ordy;
    for (int k = 1; k <= dp; k++) if (!s.v[k]) room = 1'b1;
    return !st && !fl && room;
  endfunction

  function automatic int m_occ(mst_t s, int dp);
    int c = 0;
    for (int k = 1; k <= dp; k++) c += int'(s.v[k]);
    return c;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h exp=%h time=%0t", nm, i, a, e, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < 3; i++)
      ms[i] <= !reset_n ? '0 : step_model(ms[i], dep(i), mode(i), in_valid, in_data, flush,
                                          stall, out_ready);

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [1:0] occ;
        logic evalid;
        occ = (i == 0) ? oc0 : (i == 1) ? oc1 : {1'b0, oc2};
        evalid = ms[i].v[dep(i)] && !stall;
        chk("model_out_valid", i, 32'(ov[i]), 32'(evalid));
        chk("model_in_ready", i, 32'(ir[i]),
            32'(m_in_ready(ms[i], dep(i), flush, stall, out_ready)));
        chk("model_occupancy", i, 32'(occ), 32'(m_occ(ms[i], dep(i))));
        chk("model_out_flush", i, 32'(of[i]), 32'(ms[i].fp[dep(i)]));
        if (evalid) chk("model_out_data", i, od[i], ms[i].d[dep(i)]);
      end
    end
  end

  task automatic step(logic iv, logic [31:0] id, logic fl, logic st, logic ordy);
    in_valid = iv; in_data = id; flush = fl; stall = st; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
    chk_en = 1;
    chk("reset_out_valid", 0, 32'(ov[0]), 0);
    chk("reset_out_data", 0, od[0], 0);
    chk("reset_occupancy", 0, 32'(oc0), 0);
    chk("reset_in_ready", 0, 32'(ir[0]), 1);
    chk("reset_out_flush", 0, 32'(of[0]), 0);
    chk("reset_out_valid", 2, 32'(ov[2]), 0);
    // streaming
    for (int k = 1; k <= 6; k++) begin
      step(1, 32'(k), 0, 0, 1);
      if (k == 1) begin
        chk("stream_occ1", 0, 32'(oc0), 1);
        chk("stream_d1_data", 2, od[2], 1);
        chk("stream_d1_valid", 2, 32'(ov[2]), 1);
      end
      if (k == 3) begin
        chk("stream_first_out", 0, od[0], 1);
        chk("stream_first_valid", 0, 32'(ov[0]), 1);
      end
      if (k == 4) chk("stream_second_out", 0, od[0], 2);
    end
    chk("stream_out6", 0, od[0], 4);
    chk("stream_full_occ", 0, 32'(oc0), 3);
    chk("stream_in_ready", 0, 32'(ir[0]), 1);
    chk("stream_d1_out6", 2, od[2], 6);
    chk("stream_d1_in_ready", 2, 32'(ir[2]), 1);
    // backpressure
    repeat (3) step(1, 7, 0, 0, 0);
    chk("bp_occ", 0, 32'(oc0), 3);
    chk("bp_in_ready", 0, 32'(ir[0]), 0);
    chk("bp_held_data", 0, od[0], 4);
    chk("bp_valid", 0, 32'(ov[0]), 1);
    chk("bp_d1_in_ready", 2, 32'(ir[2]), 0);
    chk("bp_d1_held", 2, od[2], 6);
    step(0, 0, 0, 0, 1);
    chk("drain_1", 0, od[0], 5);
    step(0, 0, 0, 0, 1);
    chk("drain_2", 0, od[0], 6);
    step(0, 0, 0, 0, 1);
    chk("drain_empty", 0, 32'(oc0), 0);
    // stall
    for (int k = 10; k <= 13; k++) step(1, 32'(k), 0, 0, 1);
    chk("pre_stall_out", 0, od[0], 11);
    repeat (2) begin
      step(1, 14, 0, 1, 1);
      chk("stall_out_valid", 0, 32'(ov[0]), 0);
      chk("stall_in_ready", 0, 32'(ir[0]), 0);
      chk("stall_occ", 0, 32'(oc0), 3);
      chk("stall_data", 0, od[0], 11);
    end
    step(1, 14, 0, 0, 1);
    chk("resume_1", 0, od[0], 12);
    step(1, 15, 0, 0, 1);
    chk("resume_2", 0, od[0], 13);
    repeat (3) step(0, 0, 0, 0, 1);
    // flush
    step(1, 'hA, 0, 0, 0);
    step(1, 'hB, 0, 0, 0);
    step(1, 'hC, 0, 0, 0);
    chk("fill_occ", 0, 32'(oc0), 3);
    chk("fill_occ", 1, 32'(oc1), 3);
    step(0, 0, 1, 0, 0);
    chk("flush0_occ", 0, 32'(oc0), 0);
    chk("flush0_valid", 0, 32'(ov[0]), 0);
    chk("flush_in_ready", 0, 32'(ir[0]), 0);
    chk("flush1_stage1", 1, 32'(oc1), 2);
    chk("out_flush_early", 0, 32'(of[0]), 0);
    chk("d1_out_flush", 2, 32'(of[2]), 1);
    step(1, 'hD, 0, 0, 0);
    chk("flush1_stage2", 1, 32'(oc1), 2);
    chk("flush0_accept", 0, 32'(oc0), 1);
    chk("out_flush_early2", 0, 32'(of[0]), 0);
    chk("d1_out_flush_off", 2, 32'(of[2]), 0);
    step(0, 0, 0, 0, 0);
    chk("flush1_stage3", 1, 32'(oc1), 1);
    chk("out_flush_3", 0, 32'(of[0]), 1);
    chk("out_flush_3", 1, 32'(of[1]), 1);
    step(0, 0, 0, 0, 1);
    chk("out_flush_off", 0, 32'(of[0]), 0);
    chk("survivor_valid", 1, 32'(ov[1]), 1);
    chk("survivor_data", 1, od[1], 'hD);
    chk("survivor_data", 0, od[0], 'hD);
    repeat (2) step(0, 0, 0, 0, 1);
    // asynchronous reset with a full pipe
    step(1, 'h21, 0, 0, 0);
    step(1, 'h22, 0, 0, 0);
    step(1, 'h23, 0, 0, 0);
    chk("prereset_occ", 0, 32'(oc0), 3);
    chk("prereset_valid", 0, 32'(ov[0]), 1);
    chk("prereset_data", 0, od[0], 'h21);
    in_valid = 1; in_data = 'h24; out_ready = 1;
    #1 reset_n = 0;
    #1;
    chk("async_valid", 0, 32'(ov[0]), 0);
    chk("async_data", 0, od[0], 0);
    chk("async_occ", 0, 32'(oc0), 0);
    chk("async_valid", 1, 32'(ov[1]), 0);
    chk("async_data", 2, od[2], 0);
    @(posedge clk);
    #2;
    reset_n = 1;
    for (int k = 'h31; k <= 'h33; k++) step(1, 32'(k), 0, 0, 1);
    chk("post_reset_out", 0, od[0], 'h31);
    chk("post_reset_occ", 0, 32'(oc0), 3);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("final_empty", 0, 32'(oc0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_unit_elastic.md
PIPELINE_UNIT_ELASTIC -- requirements
Module: pipeline_unit_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter FLUSH_MODE, default 0: 0 = all stages flushed at once, 1 = flush travels as a wavefront, one stage per cycle.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in_data  input  DATA_W  payload; in_valid  input  1  payload valid; in_ready  output  1  stage 1 accepts this cycle.
REQ-006 SHALL have ports: flush  input  1  kill in-flight data; stall  input  1  global freeze.
REQ-007 SHALL have ports: out_data  output  DATA_W  last-stage payload; out_valid  output  1  last stage holds valid data; out_ready  input  1  downstream accepts.
REQ-008 SHALL have ports: out_flush  output  1  flush delayed DEPTH cycles; occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-009 SHALL hold per stage i (1..DEPTH) a valid bit v[i] and data d[i]; stage 0 = inputs, stage DEPTH drives out_data/out_valid.
REQ-010 SHALL compute the advance enable combinationally: adv[DEPTH+1] = out_ready; adv[i] = ~stall & (~v[i] | adv[i+1]).
REQ-011 SHALL, when adv[i], load v[i] <= v[i-1]; load d[i] <= d[i-1] only if v[i-1]=1, else hold d[i].
REQ-012 SHALL hold v[i] and d[i] when adv[i]=0; no data is lost or duplicated, and bubbles collapse.
REQ-013 SHALL drive in_ready = adv[1] & ~flush; input transfer occurs iff in_valid & in_ready.
REQ-014 SHALL drive out_valid = v[DEPTH] & ~stall; output transfer occurs iff out_valid & out_ready.
REQ-015 SHALL keep every v[i] unchanged while stall=1 and flush is inactive for that stage (valid is not dropped).
REQ-016 SHALL give latency: data accepted at edge N appears on out_data after edge N+DEPTH-1 when never blocked.
REQ-017 SHALL sustain a throughput of one transfer per cycle when in_valid=out_ready=1 and stall=0.
REQ-018 SHALL, for FLUSH_MODE=0, clear every v[i] and zero every d[i] at the edge where flush=1.
REQ-019 SHALL, for FLUSH_MODE=1, keep a DEPTH-bit shift fp: fp[1] <= flush, fp[k] <= fp[k-1].
REQ-020 SHALL, for FLUSH_MODE=1, clear stage 1 at the edge where flush=1 and stage k>1 at the edge where fp[k-1]=1.
REQ-021 SHALL make the flush shift and out_flush advance every cycle regardless of stall or out_ready.
REQ-022 SHALL drive out_flush = flush delayed exactly DEPTH cycles in both modes.
REQ-023 SHALL give flush priority over stall and over advance for the stage it clears; a cleared stage accepts nothing that cycle.
REQ-024 SHALL register occupancy as the count of v[i]=1 after each edge, range 0..DEPTH, with no overflow.
REQ-025 SHALL handle DEPTH=1 correctly: in_ready = ~stall & (~v[1] | out_ready) & ~flush.

Reset
REQ-026 SHALL, while reset_n=0 (asynchronously), force all v[i]=0, d[i]=0, flush shift=0, out_flush=0 and occupancy=0, giving out_valid=0 and out_data=0.
REQ-027 SHALL, on reset mid-stream, discard all in-flight data; the first edge after reset_n rises operates normally.

Verification
REQ-028 SHALL be verified by a streaming test: DATA_W=32, DEPTH=3, inputs 0x1,0x2,0x3,... every cycle with out_ready=1 -> 0x1 on out_data 3 cycles after acceptance, then one item per cycle in order.
REQ-029 SHALL be verified by a backpressure test: fill the pipe with out_ready=0 -> occupancy=3, in_ready=0, data held; raise out_ready -> 3 items drain in order with no duplicates.
REQ-030 SHALL be verified by a stall test: assert stall for 2 cycles mid-stream -> out_valid=0 and in_ready=0 during stall, all v/d retained, stream resumes unchanged.
REQ-031 SHALL be verified by a flush test for FLUSH_MODE=0: pipe full (A,B,C), flush pulse -> occupancy=0 next cycle, out_flush high exactly 3 cycles after the pulse.
REQ-032 SHALL be verified by a flush test for FLUSH_MODE=1: pipe full, flush pulse -> stages 1, 2 and 3 clear on successive edges; the item accepted the cycle after the flush survives.
REQ-033 SHALL be verified by a reset test: reset_n low asynchronously mid-transfer with a full pipe -> outputs 0 immediately without waiting for a clock edge; normal streaming after release.
